result_capture_fifo: RTL and testbench

// - Downstream stage of the 4-bit-in / 20-bit-out combinational datapath; consumes its 20-bit result words.
// - Buffers results in a small FIFO with valid/ready handshakes on both sides.
// - Keeps a running modular sum and a saturating count of accepted words for checksum comparison.
// - The sink drains the buffered words at its own rate.

---
 rtl/result_capture_fifo.sv | 97 +++++++++
 tb/tb_result_capture_fifo.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/result_capture_fifo.sv
// Result capture FIFO: buffers 20-bit datapath results and keeps a running sum and
// saturating count of accepted words. Define CAPTURE_PARITY_EN to store even parity per entry.
module result_capture_fifo #(
  parameter int unsigned DATA_W = 20,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned SUM_W  = 24,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_ready,
  input  logic                     clear,
  output logic [SUM_W-1:0]         sum,
  output logic [CNT_W-1:0]         count,
  output logic                     sat,
  output logic [$clog2(DEPTH):0]   level
`ifdef CAPTURE_PARITY_EN
  ,
  output logic                     out_parity
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
`ifdef CAPTURE_PARITY_EN
  localparam int unsigned ENTRY_W = DATA_W + 1;
`else
  localparam int unsigned ENTRY_W = DATA_W;
`endif

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               push_c;
  logic               pop_c;
  logic [ENTRY_W-1:0] wr_entry_c;
  logic [ENTRY_W-1:0] head_c;

  // Handshake status comes from registered occupancy only, so out_ready never reaches in_ready.
  assign in_ready  = (level != LVL_W'(DEPTH));
  assign out_valid = (level != '0);
  assign push_c    = in_valid && in_ready;
  assign pop_c     = out_valid && out_ready;

`ifdef CAPTURE_PARITY_EN
  assign wr_entry_c = {^in_data, in_data};
`else
  assign wr_entry_c = in_data;
`endif

  assign head_c   = mem[rd_ptr];
  assign out_data = head_c[DATA_W-1:0];
`ifdef CAPTURE_PARITY_EN
  assign out_parity = head_c[DATA_W];
`endif

  // Storage, pointers and occupancy; reset wipes contents so the head reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_c) begin
        mem[wr_ptr] <= wr_entry_c;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_c && !pop_c)      level <= level + LVL_W'(1);
      else if (pop_c && !push_c) level <= level - LVL_W'(1);
    end
  end

  // Checksum statistics; clear takes effect first so a same-cycle push is counted afresh.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum   <= '0;
      count <= '0;
      sat   <= 1'b0;
    end else if (clear) begin
      sum   <= push_c ? SUM_W'(in_data) : '0;
      count <= push_c ? CNT_W'(1) : '0;
      sat   <= 1'b0;
    end else if (push_c) begin
      sum <= sum + SUM_W'(in_data);
      if (count == {CNT_W{1'b1}}) sat <= 1'b1;
      else                        count <= count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_result_capture_fifo.sv
// Self-checking bench for result_capture_fifo against a queue-based reference model.
// Honours CAPTURE_PARITY_EN when defined.
module tb_result_capture_fifo;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [19:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [19:0] out_data;
  logic        out_ready;
  logic        clear;
  logic [23:0] sum;
  logic [7:0]  count;
  logic        sat;
  logic [2:0]  level;
`ifdef CAPTURE_PARITY_EN
  logic        out_parity;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queue of buffered words plus checksum statistics.
  logic [19:0] q[$];
  logic [23:0] m_sum;
  int          m_cnt;
  bit          m_sat;

  result_capture_fifo dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .clear(clear),
    .sum(sum), .count(count), .sat(sat), .level(level)
`ifdef CAPTURE_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  // Advance one rising edge and apply the same edge to the model; returns #1 after the edge.
  task automatic tick();
    bit p, o, c, r;
    logic [19:0] d;
    r = rst;
    c = clear;
    d = in_data;
    p = in_valid && (q.size() < DEPTH);
    o = out_ready && (q.size() > 0);
    @(posedge clk);
    if (r) begin
      q.delete();
      m_sum = '0; m_cnt = 0; m_sat = 0;
    end else begin
      if (o) void'(q.pop_front());
      if (p) q.push_back(d);
      if (c) begin
        m_sum = p ? 24'(d) : 24'd0;
        m_cnt = p ? 1 : 0;
        m_sat = 0;
      end else if (p) begin
        m_sum = m_sum + 24'(d);
        if (m_cnt == 255) m_sat = 1;
        else m_cnt++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 0; in_data = '0; out_ready = 0; clear = 0;
    tick(); tick();
    rst = 0;
    repeat (5) tick();
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_tests++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level got %0d exp 0", level); end
    n_tests++; if (sum !== 24'd0) begin n_fail++; $display("FAIL reset_sum got %h exp 0", sum); end
    n_tests++; if (count !== 8'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
    n_tests++; if (out_data !== 20'd0) begin n_fail++; $display("FAIL reset_out_data got %h exp 0", out_data); end
  endtask

  task automatic test_order();
    out_ready = 0;
    in_valid = 1; in_data = 20'h00001; tick();
    in_data = 20'hFFFFF; tick();
    in_valid = 0;
    n_tests++; if (level !== 3'd2) begin n_fail++; $display("FAIL order_level got %0d exp 2", level); end
    n_tests++; if (sum !== 24'h100000) begin n_fail++; $display("FAIL order_sum got %h exp 100000", sum); end
    n_tests++; if (count !== 8'd2) begin n_fail++; $display("FAIL order_count got %0d exp 2", count); end
    out_ready = 1;
    n_tests++; if (out_valid !== 1'b1 || out_data !== 20'h00001) begin n_fail++; $display("FAIL order_first got v=%b %h exp v=1 00001", out_valid, out_data); end
    tick();
    n_tests++; if (out_valid !== 1'b1 || out_data !== 20'hFFFFF) begin n_fail++; $display("FAIL order_second got v=%b %h exp v=1 fffff", out_valid, out_data); end
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL order_empty got %b exp 0", out_valid); end
    out_ready = 0;
  endtask

  task automatic test_full();
    out_ready = 0; in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      in_data = 20'h10 + 20'(i); tick();
    end
    in_data = 20'h14;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
    tick();
    n_tests++; if (level !== 3'd4) begin n_fail++; $display("FAIL full_held_level got %0d exp 4", level); end
    n_tests++; if (out_data !== 20'h10) begin n_fail++; $display("FAIL full_head got %h exp 10", out_data); end
    out_ready = 1; tick();
    out_ready = 0;
    n_tests++; if (in_ready !== 1'b1 || level !== 3'd3) begin n_fail++; $display("FAIL full_freed got rdy=%b lvl=%0d exp rdy=1 lvl=3", in_ready, level); end
    tick();
    in_valid = 0;
    n_tests++; if (level !== 3'd4) begin n_fail++; $display("FAIL full_fifth_level got %0d exp 4", level); end
    out_ready = 1;
    for (int i = 1; i < 5; i++) begin
      n_tests++; if (out_valid !== 1'b1 || out_data !== 20'h10 + 20'(i)) begin n_fail++; $display("FAIL full_drain%0d got v=%b %h exp v=1 %h", i, out_valid, out_data, 20'h10 + 20'(i)); end
      tick();
    end
    out_ready = 0;
    n_tests++; if (level !== 3'd0) begin n_fail++; $display("FAIL full_drained got %0d exp 0", level); end
  endtask

  task automatic test_stream();
    in_valid = 1; out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      in_data = 20'(i); tick();
      n_tests++; if (level !== 3'd1 || out_data !== 20'(i)) begin n_fail++; $display("FAIL stream%0d got lvl=%0d %h exp lvl=1 %h", i, level, out_data, 20'(i)); end
    end
    in_valid = 0; tick();
    out_ready = 0;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_empty got %b exp 0", out_valid); end
  endtask

  task automatic test_saturate();
    clear = 1; tick(); clear = 0;
    in_valid = 1; out_ready = 1;
    for (int i = 0; i < 255; i++) begin
      in_data = 20'($urandom); tick();
    end
    n_tests++; if (count !== 8'd255 || sat !== 1'b0) begin n_fail++; $display("FAIL sat_at_max got cnt=%0d sat=%b exp cnt=255 sat=0", count, sat); end
    n_tests++; if (sum !== m_sum) begin n_fail++; $display("FAIL sat_sum got %h exp %h", sum, m_sum); end
    in_data = 20'($urandom); tick();
    n_tests++; if (count !== 8'd255 || sat !== 1'b1) begin n_fail++; $display("FAIL sat_over got cnt=%0d sat=%b exp cnt=255 sat=1", count, sat); end
    clear = 1; in_data = 20'h00003; tick();
    clear = 0; in_valid = 0; tick();
    n_tests++; if (sum !== 24'd3 || count !== 8'd1 || sat !== 1'b0) begin n_fail++; $display("FAIL clear_push got sum=%h cnt=%0d sat=%b exp sum=3 cnt=1 sat=0", sum, count, sat); end
    out_ready = 0;
  endtask

  task automatic test_reset_mid();
    out_ready = 0; in_valid = 1;
    repeat (3) begin in_data = 20'($urandom); tick(); end
    in_valid = 0;
    n_tests++; if (level !== 3'd3) begin n_fail++; $display("FAIL midrst_pre got %0d exp 3", level); end
    rst = 1; tick(); rst = 0;
    n_tests++; if (level !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_fifo got lvl=%0d v=%b exp lvl=0 v=0", level, out_valid); end
    n_tests++; if (sum !== 24'd0 || count !== 8'd0 || out_data !== 20'd0) begin n_fail++; $display("FAIL midrst_stats got sum=%h cnt=%0d data=%h exp 0", sum, count, out_data); end
  endtask

`ifdef CAPTURE_PARITY_EN
  task automatic test_parity();
    out_ready = 0; in_valid = 1;
    in_data = 20'h00007; tick();
    in_data = 20'h00003; tick();
    in_valid = 0;
    n_tests++; if (out_parity !== 1'b1) begin n_fail++; $display("FAIL parity_7 got %b exp 1", out_parity); end
    out_ready = 1; tick();
    n_tests++; if (out_parity !== 1'b0) begin n_fail++; $display("FAIL parity_3 got %b exp 0", out_parity); end
    tick(); out_ready = 0;
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(63) == 0);
      clear     = ($urandom_range(15) == 0);
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      in_data   = 20'($urandom);
      tick();
      n_tests++; if (int'(level) !== q.size() || out_valid !== (q.size() > 0) || in_ready !== (q.size() < DEPTH)) begin n_fail++; $display("FAIL rand%0d_occ got lvl=%0d v=%b r=%b exp lvl=%0d", i, level, out_valid, in_ready, q.size()); end
      if (q.size() > 0) begin
        n_tests++; if (out_data !== q[0]) begin n_fail++; $display("FAIL rand%0d_data got %h exp %h", i, out_data, q[0]); end
`ifdef CAPTURE_PARITY_EN
        n_tests++; if (out_parity !== ^q[0]) begin n_fail++; $display("FAIL rand%0d_parity got %b exp %b", i, out_parity, ^q[0]); end
`endif
      end
      n_tests++; if (sum !== m_sum || int'(count) !== m_cnt || sat !== m_sat) begin n_fail++; $display("FAIL rand%0d_stats got %h/%0d/%b exp %h/%0d/%b", i, sum, count, sat, m_sum, m_cnt, m_sat); end
    end
    rst = 0; clear = 0; in_valid = 0; out_ready = 0;
  endtask

  initial begin
    test_reset();
    test_order();
    test_full();
    test_stream();
    test_saturate();
    test_reset_mid();
`ifdef CAPTURE_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
